arbiter_rr: RTL and testbench
=============================

ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 SHALL have parameter AN, default 24, address width.
REQ-002 SHALL have parameter DN, default 16, data width.
REQ-003 SHALL have parameter N, default 4, number of requesters (2..8).
REQ-004 SHALL have parameter IDN, default 2, requester-ID width; $clog2(N) <= IDN.
REQ-005 SHALL have port clkSYS  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port n_reset  input  1  synchronous active-low reset.
REQ-007 SHALL have port req  input  N  per-requester request, held until acked.
REQ-008 SHALL have port wr  input  N  per-requester write(1)/read(0).
REQ-009 SHALL have port addr  input  N*AN  per-requester address; slice i = bits [i*AN +: AN].
REQ-010 SHALL have port wdata  input  N*DN  per-requester write data; slice i = bits [i*DN +: DN].
REQ-011 SHALL have port ack  output  N  one-cycle acceptance pulse per requester.
REQ-012 SHALL have port valid  output  N  one-cycle read-return strobe per requester.
REQ-013 SHALL have port rdata  output  DN  read-return data, shared by all requesters.
REQ-014 SHALL have port mem_req, mem_wr  output  1 each  request and direction to SDRAM controller.
REQ-015 SHALL have port mem_addr  output  AN; mem_data  output  DN; mem_id  output  IDN  registered request fields.
REQ-016 SHALL have port mem_ack  input  1  controller accepts request when mem_req && mem_ack.
REQ-017 SHALL have port mem_valid  input  1; mem_rdata  input  DN; mem_rid  input  IDN  read return.
REQ-018 SHALL have port busy  output  1  high while in GRANT.

Function
REQ-019 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-020 In IDLE with any req high, SHALL select winner g = first requester with req high searching from (last+1) mod N upward, wrapping.
REQ-021 On selection SHALL register mem_addr/mem_data/mem_wr from slice g, mem_id = g, assert mem_req, enter GRANT; mem_req appears the cycle after req is first sampled (1-cycle latency).
REQ-022 In GRANT SHALL hold all mem_* request fields stable and ignore req changes.
REQ-023 In GRANT on a cycle with mem_ack=1, SHALL: pulse ack[g] for exactly the following cycle, deassert mem_req, set last = g, return to IDLE.
REQ-024 SHALL allow at most one ack bit high per cycle; a requester SHALL not be re-granted in the cycle its ack is high (IDLE cycle following acceptance reevaluates).
REQ-025 With only one requester active, SHALL sustain one transfer per 3 cycles given mem_ack held high.
REQ-026 In IDLE with no req high, SHALL keep mem_req low and last unchanged.
REQ-027 SHALL register read returns: on mem_valid, next cycle valid[mem_rid]=1 and rdata=mem_rdata; mem_rid >= N SHALL produce no valid bit.
REQ-028 Read-return path SHALL operate independently of FSM state, including simultaneous ack and valid to same requester.
REQ-029 mem_ack while mem_req low SHALL be ignored.

Reset
REQ-030 When n_reset=0 at a clock edge: state=IDLE, mem_req=0, mem_wr=0, mem_addr=0, mem_data=0, mem_id=0, ack=0, valid=0, rdata=0, busy=0, last=N-1 (requester 0 wins first).
REQ-031 Reset asserted in GRANT SHALL drop mem_req next edge without issuing ack; requester retries after reset.

Configuration
REQ-032 Macro ARB_PRI0_EN: when defined, requester 0 SHALL win in IDLE whenever req[0]=1, overriding rotation (display refresh priority); last still updated on every grant.
REQ-033 Without ARB_PRI0_EN, all requesters SHALL be pure round-robin per REQ-020.

Verification
REQ-034 Reset then req=4'b1111 held, mem_ack=1 -> grant order 0,1,2,3,0 with mem_id matching, one ack pulse each, 3-cycle spacing.
REQ-035 req[2]=1 write, addr=24'hf00000, wdata=16'h1234, mem_ack delayed 5 cycles -> mem_req/mem_addr/mem_data/mem_wr stable 5 cycles, ack[2] single pulse after mem_ack.
REQ-036 mem_valid=1, mem_rid=3, mem_rdata=16'hbeef -> next cycle valid=4'b1000, rdata=16'hbeef; mem_rid=5 with N=4 -> valid=0.
REQ-037 n_reset=0 during GRANT for req[1] -> mem_req=0 next edge, no ack[1]; after release with req[1] held -> granted, ack[1] once.
REQ-038 ARB_PRI0_EN defined, req=4'b1111 held, mem_ack=1 -> requester 0 granted every transfer; undefined -> rotation per REQ-034.

Source files
------------

// File: rtl/arbiter_rr.sv
// Round-robin arbiter that funnels N requesters onto one SDRAM controller port.
// Define ARB_PRI0_EN to let requester 0 (display refresh) pre-empt the rotation.
module arbiter_rr #(
  parameter int AN  = 24,
  parameter int DN  = 16,
  parameter int N   = 4,
  parameter int IDN = 2
) (
  input  logic            clkSYS,
  input  logic            n_reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    wr,
  input  logic [N*AN-1:0] addr,
  input  logic [N*DN-1:0] wdata,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    valid,
  output logic [DN-1:0]   rdata,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [AN-1:0]   mem_addr,
  output logic [DN-1:0]   mem_data,
  output logic [IDN-1:0]  mem_id,
  input  logic            mem_ack,
  input  logic            mem_valid,
  input  logic [DN-1:0]   mem_rdata,
  input  logic [IDN-1:0]  mem_rid,
  output logic            busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_wr_q, mem_wr_d;
  logic [AN-1:0]  mem_addr_q, mem_addr_d;
  logic [DN-1:0]  mem_data_q, mem_data_d;
  logic [IDN-1:0] mem_id_q, mem_id_d;
  logic [IDN-1:0] last_q, last_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [N-1:0]   valid_q, valid_d;
  logic [DN-1:0]  rdata_q, rdata_d;

  logic           win_found;
  logic [IDN-1:0] win_idx;
  int             cand;
  logic [N-1:0]   req_sh;
  logic [N-1:0]   wr_sh;
  logic           sel_wr;
  logic [AN-1:0]  sel_addr;
  logic [DN-1:0]  sel_data;

  // First requesting index after the previous winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    req_sh    = '0;
    for (int k = 1; k <= N; k++) begin
      cand   = (int'(last_q) + k) % N;
      req_sh = req >> cand;
      if (!win_found && req_sh[0]) begin
        win_found = 1'b1;
        win_idx   = IDN'(cand);
      end
    end
`ifdef ARB_PRI0_EN
    if (req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  always_comb begin
    wr_sh    = wr >> win_idx;
    sel_wr   = wr_sh[0];
    sel_addr = AN'(addr >> (int'(win_idx) * AN));
    sel_data = DN'(wdata >> (int'(win_idx) * DN));
  end

  // The cycle carrying an ack is a dead cycle, which gives the 3-cycle transfer cadence.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_id_d   = mem_id_q;
    last_d     = last_q;
    ack_d      = '0;
    case (state_q)
      IDLE: begin
        if (win_found && (ack_q == '0)) begin
          state_d    = GRANT;
          mem_req_d  = 1'b1;
          mem_wr_d   = sel_wr;
          mem_addr_d = sel_addr;
          mem_data_d = sel_data;
          mem_id_d   = win_idx;
        end
      end
      GRANT: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          ack_d     = N'(1) << mem_id_q;
          last_d    = mem_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = '0;
    rdata_d = rdata_q;
    if (mem_valid) begin
      rdata_d = mem_rdata;
      if (int'(mem_rid) < N) valid_d = N'(1) << mem_rid;
    end
  end

  always_ff @(posedge clkSYS) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_id_q   <= '0;
      last_q     <= IDN'(N - 1);
      ack_q      <= '0;
      valid_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_id_q   <= mem_id_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ack      = ack_q;
  assign valid    = valid_q;
  assign rdata    = rdata_q;
  assign mem_req  = mem_req_q;
  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_id   = mem_id_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_arbiter_rr.sv
// Bench for arbiter_rr: directed scenarios plus randomized traffic against a
// transaction-level model; honours ARB_PRI0_EN when it is defined.
module tb_arbiter_rr;
  localparam int AN  = 24;
  localparam int DN  = 16;
  localparam int N   = 4;
  localparam int IDN = 3;

  logic            clkSYS = 1'b0;
  logic            n_reset;
  logic [N-1:0]    req;
  logic [N-1:0]    wr;
  logic [N*AN-1:0] addr;
  logic [N*DN-1:0] wdata;
  logic [N-1:0]    ack;
  logic [N-1:0]    valid;
  logic [DN-1:0]   rdata;
  logic            mem_req;
  logic            mem_wr;
  logic [AN-1:0]   mem_addr;
  logic [DN-1:0]   mem_data;
  logic [IDN-1:0]  mem_id;
  logic            mem_ack;
  logic            mem_valid;
  logic [DN-1:0]   mem_rdata;
  logic [IDN-1:0]  mem_rid;
  logic            busy;

  logic [AN-1:0]   a_addr [N];
  logic [DN-1:0]   a_data [N];

  int checks = 0;
  int errors = 0;

  always #5 clkSYS = ~clkSYS;

  arbiter_rr #(.AN(AN), .DN(DN), .N(N), .IDN(IDN)) dut (
    .clkSYS(clkSYS), .n_reset(n_reset), .req(req), .wr(wr), .addr(addr),
    .wdata(wdata), .ack(ack), .valid(valid), .rdata(rdata), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data), .mem_id(mem_id),
    .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .mem_rid(mem_rid), .busy(busy)
  );

  always_comb begin
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) begin
      addr  = addr | ((N*AN)'(a_addr[i]) << (i * AN));
      wdata = wdata | ((N*DN)'(a_data[i]) << (i * DN));
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int pickWinner(input logic [N-1:0] r, input int last);
    logic [N-1:0] sh;
`ifdef ARB_PRI0_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      sh = r >> ((last + k) % N);
      if (sh[0]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Model: m_grant is the requester whose transfer is in flight (-1 when none).
  bit             model_live = 1'b0;
  int             m_grant;
  int             m_last;
  int             m_pick;
  bit             cool;
  logic [N-1:0]   wr_sh;
  logic [N-1:0]   exp_ack, exp_valid;
  logic [DN-1:0]  exp_rdata;
  logic           exp_mem_req, exp_mem_wr;
  logic [AN-1:0]  exp_mem_addr;
  logic [DN-1:0]  exp_mem_data;
  logic [IDN-1:0] exp_mem_id;

  always @(posedge clkSYS) begin
    if (!n_reset) begin
      model_live   = 1'b1;
      m_grant      = -1;
      m_last       = N - 1;
      exp_ack      = '0;
      exp_valid    = '0;
      exp_rdata    = '0;
      exp_mem_req  = 1'b0;
      exp_mem_wr   = 1'b0;
      exp_mem_addr = '0;
      exp_mem_data = '0;
      exp_mem_id   = '0;
    end else if (model_live) begin
      exp_valid = '0;
      if (mem_valid) begin
        exp_rdata = mem_rdata;
        if (int'(mem_rid) < N) exp_valid = N'(1) << mem_rid;
      end
      if (m_grant >= 0) begin
        exp_ack = '0;
        if (mem_ack) begin
          exp_ack     = N'(1) << m_grant;
          m_last      = m_grant;
          m_grant     = -1;
          exp_mem_req = 1'b0;
        end
      end else begin
        cool    = (exp_ack != '0);
        exp_ack = '0;
        m_pick  = pickWinner(req, m_last);
        if (!cool && m_pick >= 0) begin
          m_grant      = m_pick;
          wr_sh        = wr >> m_pick;
          exp_mem_req  = 1'b1;
          exp_mem_wr   = wr_sh[0];
          exp_mem_addr = a_addr[m_pick];
          exp_mem_data = a_data[m_pick];
          exp_mem_id   = IDN'(m_pick);
        end
      end
    end
  end

  always @(negedge clkSYS) begin
    if (model_live) begin
      checkOutput("ack", ack, exp_ack);
      checkOutput("valid", valid, exp_valid);
      checkOutput("mem_req", mem_req, exp_mem_req);
      checkOutput("busy", busy, m_grant >= 0);
      if (exp_valid != '0) checkOutput("rdata", rdata, exp_rdata);
      if (exp_mem_req) begin
        checkOutput("mem_wr", mem_wr, exp_mem_wr);
        checkOutput("mem_addr", mem_addr, exp_mem_addr);
        checkOutput("mem_data", mem_data, exp_mem_data);
        checkOutput("mem_id", mem_id, exp_mem_id);
      end
    end
  end

  task automatic resetDut();
    @(negedge clkSYS);
    n_reset   = 1'b0;
    req       = '0;
    wr        = '0;
    mem_ack   = 1'b0;
    mem_valid = 1'b0;
    @(negedge clkSYS);
    @(negedge clkSYS);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_wr", mem_wr, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_data", mem_data, 0);
    checkOutput("rst_mem_id", mem_id, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_busy", busy, 0);
    n_reset = 1'b1;
  endtask

  task automatic testRotation();
    int ord [5];
    int ack_idx [$];
    int ack_cyc [$];
    int id_list [$];
    int n_ev;
    logic [N-1:0] sh;
`ifdef ARB_PRI0_EN
    ord = '{0, 0, 0, 0, 0};
`else
    ord = '{0, 1, 2, 3, 0};
`endif
    resetDut();
    req     = 4'b1111;
    wr      = '0;
    mem_ack = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clkSYS);
      if (mem_req) id_list.push_back(int'(mem_id));
      for (int i = 0; i < N; i++) begin
        sh = ack >> i;
        if (sh[0]) begin
          ack_idx.push_back(i);
          ack_cyc.push_back(c);
        end
      end
    end
    checkOutput("rot_ack_count", ack_idx.size() >= 5, 1);
    checkOutput("rot_grant_count", id_list.size() >= 5, 1);
    n_ev = (ack_idx.size() < 5) ? ack_idx.size() : 5;
    if (id_list.size() < n_ev) n_ev = id_list.size();
    for (int k = 0; k < n_ev; k++) begin
      checkOutput("rot_ack_order", ack_idx[k], ord[k]);
      checkOutput("rot_mem_id", id_list[k], ord[k]);
      if (k > 0) checkOutput("rot_spacing", ack_cyc[k] - ack_cyc[k-1], 3);
    end
    req     = '0;
    mem_ack = 1'b0;
  endtask

  task automatic testHold();
    resetDut();
    req       = 4'b0100;
    wr        = 4'b0100;
    a_addr[2] = 24'hf00000;
    a_data[2] = 16'h1234;
    mem_ack   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clkSYS);
      checkOutput("hold_mem_req", mem_req, 1);
      checkOutput("hold_mem_addr", mem_addr, 24'hf00000);
      checkOutput("hold_mem_data", mem_data, 16'h1234);
      checkOutput("hold_mem_wr", mem_wr, 1);
      checkOutput("hold_mem_id", mem_id, 2);
      checkOutput("hold_ack", ack, 0);
    end
    mem_ack = 1'b1;
    @(negedge clkSYS);
    checkOutput("hold_ack_pulse", ack, 4'b0100);
    checkOutput("hold_mem_req_drop", mem_req, 0);
    req     = '0;
    mem_ack = 1'b0;
    @(negedge clkSYS);
    checkOutput("hold_ack_single", ack, 0);
  endtask

  task automatic testReadReturn();
    resetDut();
    mem_valid = 1'b1;
    mem_rid   = 3'd3;
    mem_rdata = 16'hbeef;
    @(negedge clkSYS);
    checkOutput("rd_valid3", valid, 4'b1000);
    checkOutput("rd_rdata", rdata, 16'hbeef);
    mem_rid   = 3'd5;
    mem_rdata = 16'h5a5a;
    @(negedge clkSYS);
    checkOutput("rd_valid_oob", valid, 0);
    mem_valid = 1'b0;
    @(negedge clkSYS);
    checkOutput("rd_valid_idle", valid, 0);
  endtask

  task automatic testResetInGrant();
    int seen;
    resetDut();
    req     = 4'b0010;
    wr      = '0;
    mem_ack = 1'b0;
    @(negedge clkSYS);
    checkOutput("rig_mem_req", mem_req, 1);
    checkOutput("rig_mem_id", mem_id, 1);
    checkOutput("rig_busy", busy, 1);
    n_reset = 1'b0;
    @(negedge clkSYS);
    checkOutput("rig_mem_req_drop", mem_req, 0);
    checkOutput("rig_no_ack", ack, 0);
    n_reset = 1'b1;
    mem_ack = 1'b1;
    seen    = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clkSYS);
      if (ack[1]) begin
        seen++;
        req = '0;
      end
    end
    checkOutput("rig_ack1_count", seen, 1);
    mem_ack = 1'b0;
  endtask

  // Requesters hold req until their ack, then may re-request on a later cycle.
  task automatic applyStimulus();
    logic [N-1:0] bit_i;
    @(negedge clkSYS);
    for (int i = 0; i < N; i++) begin
      bit_i = N'(1) << i;
      if ((exp_ack & bit_i) != '0) begin
        req = req & ~bit_i;
      end else if ((req & bit_i) == '0 && $urandom_range(3) == 0) begin
        req       = req | bit_i;
        wr        = ($urandom_range(1) != 0) ? (wr | bit_i) : (wr & ~bit_i);
        a_addr[i] = AN'($urandom);
        a_data[i] = DN'($urandom);
      end else if ($urandom_range(15) == 0) begin
        a_addr[i] = AN'($urandom);
      end
    end
    mem_ack   = 1'($urandom_range(1));
    mem_valid = ($urandom_range(2) == 0);
    mem_rid   = IDN'($urandom_range(7));
    mem_rdata = DN'($urandom);
    n_reset   = ($urandom_range(149) != 0);
  endtask

  initial begin
    n_reset   = 1'b0;
    req       = '0;
    wr        = '0;
    mem_ack   = 1'b0;
    mem_valid = 1'b0;
    mem_rid   = '0;
    mem_rdata = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i] = '0;
      a_data[i] = '0;
    end
    resetDut();
    testRotation();
    testHold();
    testReadReturn();
    testResetInGrant();
    resetDut();
    for (int c = 0; c < 3000; c++) applyStimulus();
    @(negedge clkSYS);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
